bp_me_lce_data_cmd_arbiter: RTL

BP_ME_LCE_DATA_CMD_ARBITER -- requirements
Module: bp_me_lce_data_cmd_arbiter

---
 rtl/bp_me_lce_data_cmd_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/bp_me_lce_data_cmd_arbiter.sv
// rtl/bp_me_lce_data_cmd_arbiter.sv - burst-limited round-robin arbiter into a single-entry output register
module bp_me_lce_data_cmd_arbiter #(
    parameter num_src_p            = 2,
    parameter lce_data_cmd_width_p = "inv",
    parameter max_burst_p          = 1,
    localparam src_id_width_lp     = (num_src_p > 1) ? $clog2(num_src_p) : 1,
    localparam burst_width_lp      = (max_burst_p > 1) ? $clog2(max_burst_p) : 1
) (
    input  logic                                            clk_i,
    input  logic                                            reset_i,
    input  logic [num_src_p-1:0][lce_data_cmd_width_p-1:0]  lce_data_cmd_i,
    input  logic [num_src_p-1:0]                            lce_data_cmd_v_i,
    output logic [num_src_p-1:0]                            lce_data_cmd_ready_o,
    output logic [lce_data_cmd_width_p-1:0]                 lce_data_cmd_o,
    output logic                                            lce_data_cmd_v_o,
    input  logic                                            lce_data_cmd_ready_i,
    output logic [src_id_width_lp-1:0]                      src_id_o
);

    logic [lce_data_cmd_width_p-1:0] data_r;
    logic [src_id_width_lp-1:0]      src_r;
    logic                            v_r;
    logic [src_id_width_lp-1:0]      last_r;
    logic [burst_width_lp-1:0]       burst_r;

    logic [src_id_width_lp-1:0]      winner;
    logic [src_id_width_lp-1:0]      cand;
    logic                            burst_open;
    logic                            accept;
    logic                            grant;

    assign burst_open = (int'(burst_r) < (max_burst_p - 1));
    assign accept     = ~v_r | lce_data_cmd_ready_i;
    assign grant      = accept & (|lce_data_cmd_v_i) & ~reset_i;

    // Scan from farthest to nearest so the nearest valid source after last_r wins;
    // offset num_src_p wraps back to last_r itself as the final fallback.
    always_comb begin
        winner = last_r;
        cand   = last_r;
        for (int k = num_src_p; k >= 1; k--) begin
            cand = src_id_width_lp'((int'(last_r) + k) % num_src_p);
            if (lce_data_cmd_v_i[cand]) begin
                winner = cand;
            end
        end
        if (lce_data_cmd_v_i[last_r] && burst_open) begin
            winner = last_r;
        end
    end

    always_comb begin
        lce_data_cmd_ready_o = '0;
        if (grant) begin
            lce_data_cmd_ready_o[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r  <= '0;
            src_r   <= '0;
            v_r     <= 1'b0;
            last_r  <= src_id_width_lp'(num_src_p - 1);
            burst_r <= '0;
        end else if (grant) begin
            data_r <= lce_data_cmd_i[winner];
            src_r  <= winner;
            v_r    <= 1'b1;
            if (winner == last_r) begin
                if (burst_open) begin
                    burst_r <= burst_r + 1'b1;
                end
            end else begin
                last_r  <= winner;
                burst_r <= '0;
            end
        end else if (lce_data_cmd_ready_i) begin
            v_r <= 1'b0;
        end
    end

    assign lce_data_cmd_o   = data_r;
    assign src_id_o         = src_r;
    assign lce_data_cmd_v_o = v_r;

endmodule
